// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory port arbiter.
//               - C_ADDR_W / C_DATA_W : default memory address/data widths
//               - owner_e             : which requester issued a read
//               - rd_tag_t            : {valid, owner} in-flight read tag
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int C_ADDR_W = 12;
    localparam int C_DATA_W = 16;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam rd_tag_t C_TAG_NONE = '{valid: 1'b0, owner: OWNER_FETCH};

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_tag_pipe
// Description : DEPTH-deep shift register of read tags. A tag pushed at the
//               end of cycle t appears on the head outputs in cycle t+DEPTH,
//               lining up with the read data returned by the memory.
// Ports       : clock, reset      - clock, asynchronous active-high reset
//               push_valid/owner  - tag entering the pipe this cycle
//               head_valid/owner  - tag leaving the pipe this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rd_tag_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic push_valid,
    input  logic push_owner,
    output logic head_valid,
    output logic head_owner
);

    rd_tag_t r_stage [DEPTH];
    rd_tag_t w_push;

    assign w_push = '{valid: push_valid, owner: owner_e'(push_owner)};

    // Reset clears every stage so reads in flight at reset never return.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= C_TAG_NONE;
            end
        end else begin
            r_stage[0] <= w_push;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign head_valid = r_stage[DEPTH-1].valid;
    assign head_owner = r_stage[DEPTH-1].owner;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous memory port between instruction fetch
//               and data load/store. Data wins collisions unless fetch has
//               been held off for STARVE_LIMIT consecutive data grants.
//               Read returns are routed back to the issuing requester using
//               a tag pipe aligned to the memory read latency.
// Ports       : clock, reset               - clock, async active-high reset
//               if_req/if_addr/if_gnt       - fetch request / grant
//               if_rvalid/if_rdata          - fetch read return
//               d_req/d_we/d_addr/d_wdata   - data request
//               d_gnt, d_rvalid/d_rdata     - data grant / load return
//               stall                       - fetch waiting this cycle
//               m_addr/m_data/m_rw, m_q     - memory port (outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = C_ADDR_W,
    parameter int DATA_W       = C_DATA_W,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_rw,
    input  logic [DATA_W-1:0] m_q
);

    localparam int                 C_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    logic [C_CNT_W-1:0] r_starve_cnt;
    logic [C_CNT_W-1:0] w_starve_nxt;
    logic               w_if_gnt;
    logic               w_d_gnt;
    logic               w_starved;
    logic               w_push_valid;
    logic               w_push_owner;
    logic               w_head_valid;
    logic               w_head_owner;

    // ------------------------------------------------------------------
    // Arbitration: grants are suppressed while reset is held so nothing
    // downstream sees a handshake during reset.
    // ------------------------------------------------------------------
    assign w_starved = if_req && (r_starve_cnt == C_LIMIT);

    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!reset) begin
            if (d_req && !w_starved) begin
                w_d_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    // Counts data grants that bypassed a waiting fetch; saturating.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!if_req || w_if_gnt) begin
            w_starve_nxt = '0;
        end else if (w_d_gnt && (r_starve_cnt != C_LIMIT)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Issue registers. m_rw drops whenever nothing is granted, so each
    // store occupies the port for exactly one cycle. m_data only changes
    // on a store.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_addr <= '0;
            m_data <= '0;
            m_rw   <= 1'b0;
        end else begin
            m_rw <= w_d_gnt && d_we;
            if (w_d_gnt) begin
                m_addr <= d_addr;
                if (d_we) begin
                    m_data <= d_wdata;
                end
            end else if (w_if_gnt) begin
                m_addr <= if_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read tracking: every fetch and every load pushes a valid tag; stores
    // and idle cycles push a bubble so the head stays cycle-aligned.
    // ------------------------------------------------------------------
    assign w_push_valid = w_if_gnt || (w_d_gnt && !d_we);
    assign w_push_owner = w_d_gnt ? OWNER_DATA : OWNER_FETCH;

    rd_tag_pipe #(
        .DEPTH      (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .push_valid (w_push_valid),
        .push_owner (w_push_owner),
        .head_valid (w_head_valid),
        .head_owner (w_head_owner)
    );

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign stall     = if_req && !w_if_gnt && !reset;
    assign if_rvalid = w_head_valid && (w_head_owner == OWNER_FETCH);
    assign d_rvalid  = w_head_valid && (w_head_owner == OWNER_DATA);
    assign if_rdata  = m_q;
    assign d_rdata   = m_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port (m_addr/m_data/m_rw/m_q) between two requesters: instruction fetch (P1) and data load/store (P4).
- Grants one memory operation per cycle. Data has priority, with a starvation guard so fetch still progresses.
- Tracks outstanding reads and routes returning m_q data to the requester that issued the read.
- Drives the pipeline stall signal consumed by the PC/P2 logic.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 16, memory data width.
- RD_LATENCY, 2, cycles from grant to read data valid on m_q. Minimum 1.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending. Minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  instruction word valid on if_rdata
- if_rdata  out  DATA_W  instruction word
- d_req  in  1  data request
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid on d_rdata
- d_rdata  out  DATA_W  load data
- stall  out  1  high when if_req && !if_gnt
- m_addr  out  ADDR_W  memory address (registered)
- m_data  out  DATA_W  memory write data (registered)
- m_rw  out  1  1=write (registered)
- m_q  in  DATA_W  memory read data

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- Reset values: m_addr=0, m_data=0, m_rw=0, starve counter=0, all read tags invalid.
  - Outputs under reset: if_rvalid=0, d_rvalid=0, if_gnt=0, d_gnt=0, stall=0.
- Arbitration (combinational, same cycle):
  - d_req only: d_gnt=1.
  - if_req only: if_gnt=1.
  - Both requesting: d_gnt=1, unless starve_cnt==STARVE_LIMIT, in which case if_gnt=1 and d_gnt=0.
  - At most one grant per cycle.
- Starve counter:
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, or whenever if_req=0.
  - Saturates at STARVE_LIMIT.
- Issue: on a grant, at the clock edge:
  - m_addr <= granted address.
  - m_rw <= (d_gnt && d_we).
  - m_data <= d_wdata on a store; otherwise m_data holds its value.
- No grant: m_rw <= 0 and m_addr holds its value. Writes therefore last exactly one cycle.
- Read tags: a shift register RD_LATENCY deep, each entry {valid, owner}.
  - Push {1, FETCH} on a fetch grant; push {1, DATA} on a load grant; push {0, x} otherwise.
  - Stores never push a valid tag.
- Return:
  - if_rvalid = head.valid && head.owner==FETCH.
  - d_rvalid = head.valid && head.owner==DATA.
  - if_rdata = d_rdata = m_q (pass-through, no register).
  - A grant in cycle t yields rvalid in cycle t+RD_LATENCY.
- Ordering: returns are strictly in grant order; requesters never reorder.
- Read-after-write: a store followed by a load to the same address returns the new data through memory ordering. The arbiter does no forwarding.
- Requester contract: addresses and data are sampled only in the cycle gnt=1. A requester keeps req high until granted and may drop req at any time.
- Reset mid-operation: all in-flight tags are discarded. No rvalid is asserted after reset for reads granted before it.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W and DATA_W constants.
  - Owner enum: OWNER_FETCH=0, OWNER_DATA=1.
  - Tag struct {valid, owner}.
- One sub-module, rd_tag_pipe: a parameterized RD_LATENCY-deep tag shift register with async reset.
- Arbitration and issue registers stay in mem_port_arbiter.

Test Plan:
- Fetch only: if_req=1 with if_addr 0, 1, 2 on consecutive cycles.
  - if_gnt=1 and stall=0 every cycle.
  - m_addr = 0, 1, 2 one cycle after each grant.
  - if_rvalid at grant+2 with if_rdata=m_q. d_rvalid stays 0.
- Collision: if_req=1 at addr 0x010 and d_req=1 (d_we=0) at addr 0x100 in the same cycle.
  - d_gnt=1, if_gnt=0, stall=1 that cycle.
  - Fetch is granted the next cycle.
  - d_rvalid then if_rvalid on consecutive cycles, each correctly routed.
- Store: d_we=1, d_addr=0x0A0, d_wdata=0xBEEF.
  - Next cycle: m_rw=1, m_addr=0x0A0, m_data=0xBEEF for exactly one cycle.
  - d_rvalid never asserts for the store.
- Starvation, STARVE_LIMIT=4: d_req and if_req held high continuously.
  - Grant pattern repeats D,D,D,D,F.
  - stall=1 on each data-grant cycle; d_gnt=0 on the fetch cycle.
- Reset mid-read: load granted, then reset asserted the following cycle.
  - No d_rvalid afterward.
  - m_rw=0, m_addr=0 immediately, independent of the clock.
- Mixed stream: load 0x200, fetch 0x003, load 0x201 on consecutive cycles.
  - Returns arrive in cycles t+2, t+3, t+4 with the order d, if, d.
  - Data values match memory contents.
